// File: rtl/vp_mux_pkg.sv
// Shared types and helpers for the vector-lane operand selectors.
package vp_mux_pkg;

    typedef enum logic {MODE_EXPL = 1'b0, MODE_RR = 1'b1} mux_mode_t;

    // 1-based lane code meaning "no lane"
    localparam int SEL_NONE = 0;

    function automatic logic sel_legal(input int unsigned sel, input int unsigned m);
        return (sel != 0) && (sel <= m);
    endfunction

endpackage

// File: rtl/rr_counter.sv
// rr_counter: 1-based wrap-around lane pointer (1..M), sync reset to 1.
// Latency: advances on the edge where i_adv is high; no backpressure of its own.
module rr_counter #(
    parameter int M  = 5,
    parameter int SW = $clog2(M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    output logic [SW-1:0] o_ptr
);

    logic [SW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= SW'(1);
        end else if (i_adv) begin
            r_ptr <= (r_ptr == SW'(M)) ? SW'(1) : r_ptr + SW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: M-lane operand selector (explicit 1-based or round-robin); MUXSEL_ERR_EN adds sticky err.
// Latency 1 cycle, one beat per cycle; in_ready = !out_valid || out_ready.
// Backpressure: output register holds while out_ready is low, no operand is dropped.
module mux_sel_pipe
    import vp_mux_pkg::*;
#(
    parameter int N  = 20,
    parameter int M  = 5,
    parameter int SW = $clog2(M + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW-1:0]       select,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M-1:0][N-1:0] ent,
    output logic [N-1:0]        sal,
    output logic [SW-1:0]       sal_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err
);

    logic [N-1:0]  r_sal;
    logic [SW-1:0] r_sal_idx;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_is_rr;
    logic          w_legal;
    logic          w_load;
    logic [SW-1:0] w_rr_ptr;
    logic [SW-1:0] w_sel_idx;
    logic [N-1:0]  w_sel_dat;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_is_rr   = (mux_mode_t'(mode) == MODE_RR);
    assign w_legal   = sel_legal(32'(select), 32'(M));
    assign w_sel_idx = w_is_rr ? w_rr_ptr : select;
    assign w_load    = w_accept && (w_is_rr || w_legal);

    // Decode by compare rather than index so an illegal select never reads outside ent.
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < M; i++) begin
            if (w_sel_idx == SW'(i + 1)) begin
                w_sel_dat = ent[i];
            end
        end
    end

    rr_counter #(.M(M), .SW(SW)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_accept && w_is_rr),
        .o_ptr (w_rr_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sal       <= '0;
            r_sal_idx   <= SW'(SEL_NONE);
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_sal       <= w_sel_dat;
            r_sal_idx   <= w_sel_idx;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUXSEL_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_is_rr && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign sal       = r_sal;
    assign sal_idx   = r_sal_idx;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe (M=5, N=20) with a per-cycle reference model.
module tb_mux_sel_pipe;

    localparam int N  = 20;
    localparam int M  = 5;
    localparam int SW = 3;
`ifdef MUXSEL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [SW-1:0]       select;
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic [M-1:0][N-1:0] ent;
    logic [N-1:0]        sal;
    logic [SW-1:0]       sal_idx;
    logic                out_valid;
    logic                out_ready;
    logic                err;

    int checks = 0;
    int errors = 0;

    mux_sel_pipe #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .select    (select),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ent       (ent),
        .sal       (sal),
        .sal_idx   (sal_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: output register contents as the handshake rules define them.
    bit          mon_en = 1'b0;
    bit          exp_vld;
    bit          exp_err;
    int          exp_idx;
    int          exp_sal;
    int          rr;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            exp_vld = 1'b0;
            exp_sal = 0;
            exp_idx = 0;
            exp_err = 1'b0;
            rr      = 1;
            mon_en  = 1'b1;
        end else if (mon_en) begin
            acc = in_valid && (!exp_vld || out_ready);
            if (acc && mode) begin
                exp_sal = int'(ent[rr-1]);
                exp_idx = rr;
                exp_vld = 1'b1;
                rr      = (rr % M) + 1;
            end else if (acc && select >= 1 && select <= M) begin
                exp_sal = int'(ent[select-1]);
                exp_idx = int'(select);
                exp_vld = 1'b1;
            end else begin
                if (acc && ERR_EN) exp_err = 1'b1;
                if (out_ready) exp_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_out_valid", 32'(out_valid), 32'(exp_vld));
            chk("m_in_ready",  32'(in_ready),  32'(!exp_vld || out_ready));
            chk("m_sal",       32'(sal),       32'(exp_sal));
            chk("m_sal_idx",   32'(sal_idx),   32'(exp_idx));
            chk("m_err",       32'(err),       32'(exp_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic vld, input logic [N-1:0] s,
                       input logic [SW-1:0] idx);
        chk({name, "_vld"}, 32'(out_valid), 32'(vld));
        chk({name, "_sal"}, 32'(sal), 32'(s));
        chk({name, "_idx"}, 32'(sal_idx), 32'(idx));
    endtask

    initial begin
        int rr_seq [7];
        rr_seq = '{1, 2, 3, 4, 5, 1, 2};
        rst = 1'b1; select = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < M; i++) ent[i] = N'(i + 1);

        // 1: reset then explicit select 3
        tick(); tick();
        lit("rst", 1'b0, 20'h0, 3'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0; select = 3'd3; in_valid = 1'b1;
        tick();
        lit("expl3", 1'b1, 20'h00003, 3'd3);
        in_valid = 1'b0;
        tick();
        lit("drain", 1'b0, 20'h00003, 3'd3);

        // 2: round-robin wrap
        mode = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            lit("rr", 1'b1, N'(rr_seq[k]), SW'(rr_seq[k]));
        end
        in_valid = 1'b0; mode = 1'b0;
        tick();

        // 3: back-pressure with ent changing underneath
        select = 3'd2; in_valid = 1'b1;
        tick();
        lit("bp_acc", 1'b1, 20'h00002, 3'd2);
        out_ready = 1'b0; select = 3'd4; ent[1] = 20'hFFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            lit("bp_hold", 1'b1, 20'h00002, 3'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        tick();
        lit("bp_reload", 1'b1, 20'h00004, 3'd4);
        ent[1] = 20'h00002; in_valid = 1'b0;
        tick();

        // 4: illegal selects
        select = 3'd0; in_valid = 1'b1;
        tick();
        lit("ill0", 1'b0, 20'h00004, 3'd4);
        chk("ill0_err", 32'(err), 32'(ERR_EN));
        select = 3'd6;
        tick();
        lit("ill6", 1'b0, 20'h00004, 3'd4);
        chk("ill6_err", 32'(err), 32'(ERR_EN));
        in_valid = 1'b0;
        tick();

        // 5: mode switch keeps rr_ptr (now 3), then mid-operation reset
        mode = 1'b1; in_valid = 1'b1;
        tick();
        lit("ms_rr3", 1'b1, 20'h00003, 3'd3);
        mode = 1'b0; select = 3'd1;
        tick();
        lit("ms_expl1", 1'b1, 20'h00001, 3'd1);
        mode = 1'b1;
        tick();
        lit("ms_rr4", 1'b1, 20'h00004, 3'd4);
        chk("ms_err_sticky", 32'(err), 32'(ERR_EN));
        in_valid = 1'b0; rst = 1'b1;
        tick();
        lit("mid_rst", 1'b0, 20'h0, 3'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        rst = 1'b0; in_valid = 1'b1;
        tick();
        lit("post_rst_rr", 1'b1, 20'h00001, 3'd1);

        // stalled round-robin offers must not advance the pointer
        out_ready = 1'b0;
        tick(); tick();
        lit("rr_stall", 1'b1, 20'h00001, 3'd1);
        out_ready = 1'b1;
        tick();
        lit("rr_after_stall", 1'b1, 20'h00002, 3'd2);
        in_valid = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Registered, parametrised successor to the vector unit's 5-input N-bit operand selector. Selects one of M N-bit lanes, by explicit 1-based select or by an internal round-robin pointer, and presents the result through a one-stage output register with valid/ready handshaking. It sits between the vector register-file read ports and the lane ALU inputs. It absorbs ALU back-pressure without dropping operands.

## Interface
- N, default 20: data width per input lane.
- M, default 5: number of input lanes, range 2..15.
- SW, default $clog2(M+1): select width, derived. Do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- select  in  SW  explicit lane select, 1-based: value k picks ent[k-1]. Values 0 and >M are illegal.
- mode  in  1  0 = explicit select, 1 = round-robin.
- in_valid  in  1  an input beat is offered.
- in_ready  out  1  the block can accept a beat.
- ent  in  M×N  packed lane inputs; ent[i] is lane i+1.
- sal  out  N  registered selected data.
- sal_idx  out  SW  1-based lane number that produced sal.
- out_valid  out  1  sal and sal_idx are valid.
- out_ready  in  1  the consumer accepts sal.
- err  out  1  sticky flag for an illegal select.

## Operation
- Accept: a beat is accepted when in_valid && in_ready.
- Ready: in_ready = !out_valid || out_ready. It is combinational, with no dependency on in_valid.
- Explicit mode, legal select k:
  - sal <= ent[k-1], sal_idx <= k, out_valid <= 1.
- Explicit mode, illegal select (0 or >M):
  - The beat is consumed and no output is produced.
  - out_valid <= 0 if out_ready, otherwise it holds.
  - The err behaviour is set by the configuration macro.
- Round-robin mode:
  - select is ignored.
  - sal <= ent[rr_ptr-1], sal_idx <= rr_ptr.
  - rr_ptr advances by 1, wrapping from M to 1.
- rr_ptr advances only on accepted beats in round-robin mode. It holds in explicit mode and when no beat is accepted.
- Mode change: takes effect on the next accepted beat. rr_ptr is not reset by a mode change.
- Drain: out_valid && out_ready with no accept gives out_valid <= 0 on the next edge. sal and sal_idx keep their last values.
- Stall: out_valid && !out_ready means sal, sal_idx and out_valid hold. in_ready is low.
- Simultaneous drain and accept: the register reloads with the new beat and out_valid stays 1.

## Timing
- Reset values, on the first edge with rst=1: sal=0, sal_idx=0, out_valid=0, err=0, rr_ptr=1.
- in_ready is 1 after reset.
- Reset mid-operation discards any pending output beat.
- Latency: a beat accepted at edge t is visible on sal/out_valid after edge t, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1.
- ent and select are sampled only at the accepting edge. Changing ent while stalled has no effect on sal.
- There is no combinational path from ent/select to sal.

## Configuration
- Macro: MUXSEL_ERR_EN.
- Defined:
  - err is set on the edge that accepts an illegal explicit select.
  - err stays set until rst.
  - A round-robin beat never sets err.
- Undefined:
  - err is tied to 0 and there is no err register.
  - An illegal select is still consumed silently, with no output beat.

## Structure
- Shared package vp_mux_pkg holds:
  - typedef enum logic {MODE_EXPL=1'b0, MODE_RR=1'b1} mux_mode_t;
  - constant SEL_NONE = 0, the 1-based "no lane" code.
  - function sel_legal(sel, m), returning sel!=0 && sel<=m.
- Sub-module rr_counter: 1-based wrap-around pointer with sync reset to 1 and an advance enable, parameter M. It is reusable by other vector-lane schedulers.
- The output register, handshake and select decode live in mux_sel_pipe itself.

## Test plan
All scenarios use M=5, N=20.
1. Reset and explicit select: hold rst high 2 cycles, then release. Present ent = {lane1=0x00001, lane2=0x00002, lane3=0x00003, lane4=0x00004, lane5=0x00005}, mode=0, out_ready=1. Drive select=3, in_valid=1 for 1 cycle. Required: during reset sal=0, out_valid=0, in_ready=1. Next cycle sal=0x00003, sal_idx=3, out_valid=1. The cycle after, out_valid=0.
2. Round-robin wrap: mode=1, in_valid=1, out_ready=1 for 7 cycles. Required: sal_idx sequence 1,2,3,4,5,1,2 and sal matches each lane.
3. Back-pressure: accept select=2, then hold out_ready=0 for 3 cycles while changing ent[1] to 0xFFFFF. Required: sal stays 0x00002, in_ready=0, out_valid=1. Raise out_ready with in_valid=1 and select=4. Required: sal=0x00004 next cycle with out_valid continuously 1.
4. Illegal select: select=0, then select=6, with in_valid=1. Required: no output beat. With MUXSEL_ERR_EN, err=1 from the first bad beat until rst. Without the macro, err=0 throughout.
5. Mode switch and mid-operation reset: run round-robin to rr_ptr=4, switch to mode=0 with select=1, then back to mode=1. Required: outputs are lane1 then lane4, so rr_ptr was preserved. Assert rst while out_valid=1. Required: out_valid=0, sal=0 and the next round-robin beat is lane1.
